// File: rtl/segment_readback.sv
// Debounces a pair of seven-segment digit patterns, decodes them to a 0..99 reading
// and presents each new reading on a valid/ready output slot with wrap/skip/overrun flags.
module segment_readback #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] digit1,
    input  logic [6:0] digit2,
    input  logic       ready,
    output logic       valid,
    output logic [6:0] value,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       wrap,
    output logic       skip,
    output logic       error,
    output logic       overrun
);

    localparam logic [3:0] STABLE_N  = 4'(STABLE_CYCLES);
    localparam logic [3:0] STABLE_M1 = 4'(STABLE_CYCLES - 1);

    // Returns {decodable, digit}; bit order g,f,e,d,c,b,a.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0111111: r = {1'b1, 4'd0};
            7'b0000110: r = {1'b1, 4'd1};
            7'b1011011: r = {1'b1, 4'd2};
            7'b1001111: r = {1'b1, 4'd3};
            7'b1100110: r = {1'b1, 4'd4};
            7'b1101101: r = {1'b1, 4'd5};
            7'b1111101: r = {1'b1, 4'd6};
            7'b0000111: r = {1'b1, 4'd7};
            7'b1111111: r = {1'b1, 4'd8};
            7'b1101111: r = {1'b1, 4'd9};
            default:    r = 5'd0;
        endcase
        return r;
    endfunction

    logic [13:0] sample_q, sample_d, last_pat_q, last_pat_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        have_last_q, have_last_d, pending_q, pending_d;
    logic        valid_q, valid_d, wrap_q, wrap_d, skip_q, skip_d;
    logic        error_q, error_d, overrun_q, overrun_d;
    logic [6:0]  value_q, value_d;
    logic [3:0]  tens_q, tens_d, ones_q, ones_d;

    logic [13:0] pattern;
    logic [4:0]  dec1, dec2;
    logic [3:0]  tens_n, ones_n;
    logic [6:0]  val_n;
    logic        match, stable, first_stable, blank, decodable;
    logic        is_new, slot_free, want, capture, wrap_n, skip_n;

    always_comb begin
        pattern      = {digit1, digit2};
        match        = (pattern == sample_q);
        stable       = match && (cnt_q >= STABLE_M1);
        first_stable = match && (cnt_q == STABLE_M1);
        dec1         = seg_decode(digit1);
        dec2         = seg_decode(digit2);
        blank        = (pattern == 14'd0);
        // A blank tens digit reads as a leading zero.
        decodable    = dec2[4] && (dec1[4] || (digit1 == 7'd0));
        tens_n       = dec1[4] ? dec1[3:0] : 4'd0;
        ones_n       = dec2[3:0];
        val_n        = {tens_n, 3'b000} + {2'b00, tens_n, 1'b0} + {3'b000, ones_n};
        is_new       = !have_last_q || (pattern != last_pat_q);
        slot_free    = !valid_q || ready;
        want         = stable && decodable && is_new;
        capture      = want && slot_free;
        // value_q always holds the last accepted reading once have_last_q is set.
        wrap_n       = have_last_q && (val_n == 7'd0) && (value_q == 7'd99);
        skip_n       = have_last_q && !wrap_n && (val_n != 7'(value_q + 7'd1));

        sample_d    = pattern;
        cnt_d       = !match ? 4'd1 : ((cnt_q == STABLE_N) ? cnt_q : 4'(cnt_q + 4'd1));
        last_pat_d  = last_pat_q;
        have_last_d = have_last_q;
        valid_d     = valid_q;
        value_d     = value_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        wrap_d      = wrap_q;
        skip_d      = skip_q;
        error_d     = first_stable && !blank && !decodable;
        pending_d   = want && !slot_free;
        // A held-off reading is lost if the input moves before the slot frees up.
        overrun_d   = overrun_q || (pending_q && !match);

        // Output slot: a reading transfers on an edge where valid and ready are both 1;
        // data stays frozen while valid is 1 and ready is 0.
        if (capture) begin
            valid_d     = 1'b1;
            value_d     = val_n;
            tens_d      = tens_n;
            ones_d      = ones_n;
            wrap_d      = wrap_n;
            skip_d      = skip_n;
            last_pat_d  = pattern;
            have_last_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q    <= '0;
            cnt_q       <= '0;
            last_pat_q  <= '0;
            have_last_q <= 1'b0;
            pending_q   <= 1'b0;
            valid_q     <= 1'b0;
            value_q     <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            wrap_q      <= 1'b0;
            skip_q      <= 1'b0;
            error_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sample_q    <= sample_d;
            cnt_q       <= cnt_d;
            last_pat_q  <= last_pat_d;
            have_last_q <= have_last_d;
            pending_q   <= pending_d;
            valid_q     <= valid_d;
            value_q     <= value_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            wrap_q      <= wrap_d;
            skip_q      <= skip_d;
            error_q     <= error_d;
            overrun_q   <= overrun_d;
        end
    end

    assign valid    = valid_q;
    assign value    = value_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign wrap     = wrap_q;
    assign skip     = skip_q;
    assign error    = error_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_segment_readback.sv
// Bench for segment_readback: directed scenarios plus randomized hold/backpressure traffic
// compared edge by edge against a run-length/reading-history model.
module tb_segment_readback;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset, ready;
  logic [6:0] digit1, digit2;
  logic valid, wrap, skip, error, overrun;
  logic [6:0] value;
  logic [3:0] bcd_tens, bcd_ones;

  int checks = 0;
  int passed = 0;

  segment_readback #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .digit1(digit1), .digit2(digit2), .ready(ready),
    .valid(valid), .value(value), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .wrap(wrap), .skip(skip), .error(error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  // ---------------- reference model ----------------
  logic [13:0] m_prev_in, m_last_pat;
  logic m_have_prev, m_have_last, m_pending;
  int m_run, m_last_val;
  logic m_valid, m_wrap, m_skip, m_error, m_overrun;
  logic [6:0] m_value;
  logic [3:0] m_tens, m_ones;

  task automatic model_edge(input logic rst, input logic [13:0] p, input logic rdy);
    int t, o, v;
    logic changed, stable, first, ok, blank, free, want;
    if (rst) begin
      m_prev_in = '0; m_last_pat = '0; m_have_prev = 0; m_have_last = 0; m_pending = 0;
      m_run = 0; m_last_val = 0; m_valid = 0; m_wrap = 0; m_skip = 0; m_error = 0;
      m_overrun = 0; m_value = '0; m_tens = '0; m_ones = '0;
      return;
    end
    changed = !m_have_prev || (p != m_prev_in);
    m_run = changed ? 1 : (m_run < 1000 ? m_run + 1 : m_run);
    stable = (m_run >= S);
    first = (m_run == S);
    t = -1; o = -1;
    for (int k = 0; k < 10; k++) begin
      if (seg_tab[k] == p[13:7]) t = k;
      if (seg_tab[k] == p[6:0]) o = k;
    end
    if (p[13:7] == 7'd0 && o >= 0) t = 0;
    blank = (p == 14'd0);
    ok = (t >= 0) && (o >= 0);
    free = !m_valid || rdy;
    want = stable && ok && (!m_have_last || p != m_last_pat);
    if (m_pending && changed) m_overrun = 1;
    m_error = first && !blank && !ok;
    if (want && free) begin
      v = t * 10 + o;
      m_wrap = m_have_last && v == 0 && m_last_val == 99;
      m_skip = m_have_last && !m_wrap && v != m_last_val + 1;
      m_value = 7'(v); m_tens = 4'(t); m_ones = 4'(o); m_valid = 1;
      m_last_pat = p; m_last_val = v; m_have_last = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    m_pending = want && !free;
    m_prev_in = p;
    m_have_prev = 1;
  endtask

  function automatic logic [19:0] dut_vec();
    return {valid, value, bcd_tens, bcd_ones, wrap, skip, error, overrun};
  endfunction

  function automatic logic [19:0] mdl_vec();
    return {m_valid, m_value, m_tens, m_ones, m_wrap, m_skip, m_error, m_overrun};
  endfunction

  function automatic logic [13:0] pat(input int t, input int o);
    logic [6:0] a, b;
    a = (t < 0) ? 7'd0 : seg_tab[t];
    b = (o < 0) ? 7'd0 : seg_tab[o];
    return {a, b};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic [13:0] p, input logic rdy);
    reset = rst;
    {digit1, digit2} = p;
    ready = rdy;
    @(posedge clk);
    model_edge(rst, p, rdy);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(1, pat(5, 5), 1);
    step(1, pat(5, 5), 0);
    checks++;
    if (dut_vec() !== 20'd0) $display("FAIL reset_state: got %h expected %h", dut_vec(), 20'd0);
    else passed++;
  endtask

  task automatic test_basic();
    step(1, 14'd0, 1);
    for (int i = 1; i <= 6; i++) begin
      step(0, pat(0, 2), 1);
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL basic_model e%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      else passed++;
      if (i == 4) begin
        checks++;
        if (dut_vec() !== {1'b1, 7'd2, 4'd0, 4'd2, 4'b0000})
          $display("FAIL basic_capture: got %h expected %h", dut_vec(), {1'b1, 7'd2, 4'd0, 4'd2, 4'b0000});
        else passed++;
      end
      if (i == 5 || i == 3) begin
        checks++;
        if (valid !== 1'b0) $display("FAIL basic_valid_low e%0d: got %b expected 0", i, valid);
        else passed++;
      end
    end
  endtask

  task automatic test_debounce();
    step(1, 14'd0, 1);
    for (int i = 1; i <= 7; i++) begin
      step(0, (i <= 3) ? pat(0, 5) : pat(0, 6), 1);
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL debounce_model e%0d: got %h expected %h", i, dut_vec(), mdl_vec());
      else passed++;
    end
    checks++;
    if ({valid, value, error} !== {1'b1, 7'd6, 1'b0})
      $display("FAIL debounce_value: got v=%b val=%0d err=%b expected v=1 val=6 err=0", valid, value, error);
    else passed++;
  endtask

  task automatic test_wrap_skip();
    step(1, 14'd0, 1);
    for (int i = 0; i < 4; i++) step(0, pat(9, 9), 1);
    for (int i = 0; i < 4; i++) step(0, pat(0, 0), 1);
    checks++;
    if ({valid, value, wrap, skip} !== {1'b1, 7'd0, 1'b1, 1'b0})
      $display("FAIL wrap_flag: got v=%b val=%0d w=%b s=%b expected 1 0 1 0", valid, value, wrap, skip);
    else passed++;
    for (int i = 0; i < 4; i++) step(0, pat(0, 5), 1);
    checks++;
    if ({valid, value, wrap, skip} !== {1'b1, 7'd5, 1'b0, 1'b1})
      $display("FAIL skip_flag: got v=%b val=%0d w=%b s=%b expected 1 5 0 1", valid, value, wrap, skip);
    else passed++;
  endtask

  task automatic test_backpressure();
    step(1, 14'd0, 0);
    for (int i = 0; i < 4; i++) step(0, pat(0, 5), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, pat(0, 6), 0);
      checks++;
      if ({valid, value} !== {1'b1, 7'd5}) $display("FAIL bp_frozen e%0d: got v=%b val=%0d expected 1 5", i, valid, value);
      else passed++;
    end
    step(0, pat(0, 6), 1);
    checks++;
    if ({valid, value, skip} !== {1'b1, 7'd6, 1'b0})
      $display("FAIL bp_release: got v=%b val=%0d s=%b expected 1 6 0", valid, value, skip);
    else passed++;
    for (int i = 0; i < 4; i++) step(0, pat(0, 7), 0);
    checks++;
    if (overrun !== 1'b0) $display("FAIL bp_no_overrun_yet: got %b expected 0", overrun);
    else passed++;
    step(0, pat(0, 8), 0);
    checks++;
    if (overrun !== 1'b1) $display("FAIL bp_overrun: got %b expected 1", overrun);
    else passed++;
    for (int i = 0; i < 6; i++) step(0, pat(0, 8), 1);
    checks++;
    if ({overrun, value} !== {1'b1, 7'd8}) $display("FAIL bp_overrun_sticky: got ov=%b val=%0d expected 1 8", overrun, value);
    else passed++;
  endtask

  task automatic test_error();
    step(1, 14'd0, 1);
    for (int i = 1; i <= 10; i++) begin
      step(0, {7'd0, 7'b1110000}, 1);
      checks++;
      if ({error, valid} !== {(i == 4) ? 1'b1 : 1'b0, 1'b0})
        $display("FAIL error_pulse e%0d: got err=%b v=%b expected err=%b v=0", i, error, valid, (i == 4));
      else passed++;
    end
  endtask

  task automatic test_reset_midflight();
    step(1, 14'd0, 0);
    for (int i = 0; i < 4; i++) step(0, pat(4, 2), 0);
    for (int i = 0; i < 4; i++) step(0, pat(1, 1), 0);
    step(1, pat(1, 1), 0);
    checks++;
    if (dut_vec() !== 20'd0) $display("FAIL midflight_reset: got %h expected %h", dut_vec(), 20'd0);
    else passed++;
    for (int i = 0; i < 4; i++) step(0, pat(-1, 3), 1);
    checks++;
    if ({valid, value, wrap, skip, overrun} !== {1'b1, 7'd3, 1'b0, 1'b0, 1'b0})
      $display("FAIL post_reset_read: got %h expected v=1 val=3 w=0 s=0 ov=0", dut_vec());
    else passed++;
  endtask

  task automatic test_random();
    int seq_v, kind, hold, t, o;
    logic [13:0] p;
    seq_v = 0;
    step(1, 14'd0, 1);
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 99);
      if (kind < 40) begin
        t = $urandom_range(0, 9); o = $urandom_range(0, 9);
        if (t == 0 && $urandom_range(0, 1)) t = -1;
        p = pat(t, o);
      end else if (kind < 70) begin
        seq_v = (seq_v + 1) % 100;
        t = seq_v / 10; o = seq_v % 10;
        p = pat((t == 0) ? -1 : t, o);
      end else if (kind < 80) begin
        p = 14'd0;
      end else begin
        p = 14'($urandom);
      end
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        step(($urandom_range(0, 199) == 0), p, ($urandom_range(0, 9) < 6));
        checks++;
        if (dut_vec() !== mdl_vec()) $display("FAIL random_model n%0d: got %h expected %h", n, dut_vec(), mdl_vec());
        else passed++;
      end
    end
  endtask

  initial begin
    reset = 1; ready = 0; digit1 = '0; digit2 = '0;
    test_reset();
    test_basic();
    test_debounce();
    test_wrap_skip();
    test_backpressure();
    test_error();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
